// File: rtl/pint_master_if.sv
// pint_master_if
//   Command / response port between ice_controller and pint_master.
//   cmd_*  : one 32-bit command per cmd_valid & cmd_ready handshake
//            (cmd_read = 1 for a read, 0 for a write; cmd_data is the write word).
//   rsp_*  : one read result per rsp_valid & rsp_ready handshake
//            (rsp_err = 1 when the slave never signalled ready; rsp_data is 0 then).
//   master : the command issuer (ice_controller side).
//   slave  : the PINT sequencer (pint_master).
interface pint_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/pint_master.sv
// pint_master
//   Sequencing controller for the PINT serial interface. Takes 32-bit write
//   and read commands from ice_controller, generates PINT_CLK from clk,
//   serializes / deserializes words MSB-first, owns PINT_RESETN sequencing
//   and the read-ready timeout.
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset (full re-initialisation)
//   soft_reset   one-cycle pulse: abort the current operation, redo PINT reset
//   host         command / response port (pint_master_if.slave)
//   busy         high whenever the controller is not idle
//   PINT_CLK     serial clock, low when idle
//   PINT_WRREQ   write frame active
//   PINT_WRDATA  current write bit
//   PINT_RDREQ   read request
//   PINT_RDRDY   slave ready (asynchronous, synchronized here)
//   PINT_RDDATA  read bit (asynchronous, synchronized here)
//   PINT_RESETN  active-low slave reset
//
// Bit timing: one bit = CLK_DIV clk cycles with PINT_CLK low, then CLK_DIV
// cycles high. Outputs only change on the first cycle of a low phase, and
// inputs are taken on the last cycle of a high phase, giving the slave a
// full phase of setup either way.
module pint_master #(
    parameter int CLK_DIV    = 4,    // PINT_CLK half-period in clk cycles, >= 3
    parameter int RST_CYCLES = 64,   // clk cycles PINT_RESETN is held low
    parameter int RD_TIMEOUT = 255   // sample points to wait for RDRDY
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         soft_reset,
    pint_master_if.slave host,
    output logic         busy,
    output logic         PINT_CLK,
    output logic         PINT_WRREQ,
    output logic         PINT_WRDATA,
    output logic         PINT_RDREQ,
    input  logic         PINT_RDRDY,
    input  logic         PINT_RDDATA,
    output logic         PINT_RESETN
);

    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int EDGE_W = $clog2(RD_TIMEOUT + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);

    // Last cycle of the low phase (PINT_CLK rises next) and last cycle of
    // the high phase (sample point; PINT_CLK falls next).
    localparam logic [PH_W-1:0]   PH_MID    = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(RD_TIMEOUT - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_WR_SHIFT = 3'd2;
    localparam logic [2:0] ST_WR_GAP   = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD_SHIFT = 3'd5;
    localparam logic [2:0] ST_RD_DONE  = 3'd6;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous slave inputs.
    // Bit 1 = RDRDY, bit 0 = RDDATA.
    // ------------------------------------------------------------------
    logic [1:0] pin_async;
    logic [1:0] pin_sync;
    logic       rdrdy_s;
    logic       rddata_s;

    assign pin_async = {PINT_RDRDY, PINT_RDDATA};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pin_async[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    assign rdrdy_s  = pin_sync[1];
    assign rddata_s = pin_sync[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_reg,     state_next;
    logic [PH_W-1:0]   ph_cnt_reg,    ph_cnt_next;
    logic [4:0]        bit_cnt_reg,   bit_cnt_next;
    logic [EDGE_W-1:0] edge_cnt_reg,  edge_cnt_next;
    logic [RST_W-1:0]  rst_cnt_reg,   rst_cnt_next;
    logic [31:0]       shreg_reg,     shreg_next;
    logic              pint_clk_reg,  pint_clk_next;
    logic              wrreq_reg,     wrreq_next;
    logic              wrdata_reg,    wrdata_next;
    logic              rdreq_reg,     rdreq_next;
    logic              resetn_reg,    resetn_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_data_reg,  rsp_data_next;
    logic              rsp_err_reg,   rsp_err_next;

    logic ph_mid;
    logic ph_end;
    logic clk_run;    // PINT_CLK toggles in this state
    logic phase_run;  // bit-period counter advances in this state

    assign ph_mid    = (ph_cnt_reg == PH_MID);
    assign ph_end    = (ph_cnt_reg == PH_LAST);
    assign clk_run   = (state_reg == ST_WR_SHIFT) || (state_reg == ST_RD_WAIT) ||
                       (state_reg == ST_RD_SHIFT);
    // The write gap counts a full bit period with PINT_CLK held low.
    assign phase_run = clk_run || (state_reg == ST_WR_GAP);

    always_comb begin
        state_next     = state_reg;
        ph_cnt_next    = ph_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        edge_cnt_next  = edge_cnt_reg;
        rst_cnt_next   = rst_cnt_reg;
        shreg_next     = shreg_reg;
        pint_clk_next  = pint_clk_reg;
        wrreq_next     = wrreq_reg;
        wrdata_next    = wrdata_reg;
        rdreq_next     = rdreq_reg;
        resetn_next    = resetn_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;

        // Common bit-period timing.
        if (phase_run) begin
            if (ph_end) begin
                ph_cnt_next = '0;
            end else begin
                ph_cnt_next = ph_cnt_reg + 1'b1;
            end
        end
        if (clk_run) begin
            if (ph_mid) begin
                pint_clk_next = 1'b1;
            end else if (ph_end) begin
                pint_clk_next = 1'b0;
            end
        end

        case (state_reg)
            ST_RST_HOLD: begin
                if (rst_cnt_reg == RST_LAST) begin
                    resetn_next = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end

            ST_IDLE: begin
                if (host.cmd_valid) begin
                    ph_cnt_next   = '0;
                    bit_cnt_next  = '0;
                    pint_clk_next = 1'b0;
                    if (host.cmd_read) begin
                        state_next    = ST_RD_WAIT;
                        rdreq_next    = 1'b1;
                        edge_cnt_next = '0;
                    end else begin
                        state_next  = ST_WR_SHIFT;
                        shreg_next  = host.cmd_data;
                        wrreq_next  = 1'b1;
                        wrdata_next = host.cmd_data[31];
                    end
                end
            end

            ST_WR_SHIFT: begin
                if (ph_end) begin
                    if (bit_cnt_reg == 5'd31) begin
                        state_next  = ST_WR_GAP;
                        wrreq_next  = 1'b0;
                        wrdata_next = 1'b0;
                    end else begin
                        shreg_next   = {shreg_reg[30:0], 1'b0};
                        wrdata_next  = shreg_reg[30];
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            ST_WR_GAP: begin
                if (ph_end) begin
                    state_next = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                if (ph_end) begin
                    if (rdrdy_s) begin
                        state_next   = ST_RD_SHIFT;
                        bit_cnt_next = '0;
                    end else if (edge_cnt_reg == EDGE_LAST) begin
                        state_next     = ST_RD_DONE;
                        rdreq_next     = 1'b0;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_data_next  = '0;
                    end else begin
                        edge_cnt_next = edge_cnt_reg + 1'b1;
                    end
                end
            end

            ST_RD_SHIFT: begin
                if (ph_end) begin
                    shreg_next = {shreg_reg[30:0], rddata_s};
                    if (bit_cnt_reg == 5'd31) begin
                        state_next     = ST_RD_DONE;
                        rdreq_next     = 1'b0;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b0;
                        rsp_data_next  = {shreg_reg[30:0], rddata_s};
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            ST_RD_DONE: begin
                if (host.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next   = ST_RST_HOLD;
                rst_cnt_next = '0;
                resetn_next  = 1'b0;
            end
        endcase

        // Abort wins over anything decided above, including an accept or a
        // response handshake in the same cycle; the command is simply dropped.
        if (soft_reset) begin
            state_next     = ST_RST_HOLD;
            rst_cnt_next   = '0;
            ph_cnt_next    = '0;
            resetn_next    = 1'b0;
            pint_clk_next  = 1'b0;
            wrreq_next     = 1'b0;
            wrdata_next    = 1'b0;
            rdreq_next     = 1'b0;
            rsp_valid_next = 1'b0;
            rsp_err_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RST_HOLD;
            ph_cnt_reg    <= '0;
            bit_cnt_reg   <= '0;
            edge_cnt_reg  <= '0;
            rst_cnt_reg   <= '0;
            shreg_reg     <= '0;
            pint_clk_reg  <= 1'b0;
            wrreq_reg     <= 1'b0;
            wrdata_reg    <= 1'b0;
            rdreq_reg     <= 1'b0;
            resetn_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ph_cnt_reg    <= ph_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            edge_cnt_reg  <= edge_cnt_next;
            rst_cnt_reg   <= rst_cnt_next;
            shreg_reg     <= shreg_next;
            pint_clk_reg  <= pint_clk_next;
            wrreq_reg     <= wrreq_next;
            wrdata_reg    <= wrdata_next;
            rdreq_reg     <= rdreq_next;
            resetn_reg    <= resetn_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: PINT pins come straight from flops so they never glitch.
    // ------------------------------------------------------------------
    assign host.cmd_ready = (state_reg == ST_IDLE);
    assign host.rsp_valid = rsp_valid_reg;
    assign host.rsp_data  = rsp_data_reg;
    assign host.rsp_err   = rsp_err_reg;
    assign busy           = (state_reg != ST_IDLE);

    assign PINT_CLK    = pint_clk_reg;
    assign PINT_WRREQ  = wrreq_reg;
    assign PINT_WRDATA = wrdata_reg;
    assign PINT_RDREQ  = rdreq_reg;
    assign PINT_RESETN = resetn_reg;

endmodule
